// File: rtl/mario_motion_resolver.sv
// mario_motion_resolver
// Once per frame, walks the 16x16 Mario sprite one pixel at a time against
// the screen bounds, the floor and a single solid brick platform. It then
// returns the resolved top-left position and the contact flags for that frame.

module mario_motion_resolver #(
  parameter int MARIO_SIZE = 16,
  parameter int X_MAX      = 639,
  parameter int FLOOR_Y    = 416,
  parameter int PLAT_X0    = 96,
  parameter int PLAT_X1    = 175,
  parameter int PLAT_Y0    = 368,
  parameter int PLAT_Y1    = 383,
  parameter int RESET_X    = 0,
  parameter int RESET_Y    = 100
) (
  input  logic       clk_50,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [9:0] X_Pos,
  input  logic [9:0] Y_Pos,
  input  logic [5:0] Right_V,
  input  logic [5:0] Left_V,
  input  logic [5:0] Up_V,
  input  logic [5:0] Down_V,
  output logic [9:0] X_Out,
  output logic [9:0] Y_Out,
  output logic       Done,
  output logic       Busy,
  output logic       Grounded,
  output logic       Hit_Head,
  output logic       Hit_Wall
);

  // All geometry is compared at 11 bits, so the far edge (c + 15) never wraps.
  localparam logic [10:0] EDGE_W  = 11'(MARIO_SIZE - 1);
  localparam logic [10:0] XMAX_W  = 11'(X_MAX);
  localparam logic [10:0] FLOOR_W = 11'(FLOOR_Y);
  localparam logic [10:0] PX0_W   = 11'(PLAT_X0);
  localparam logic [10:0] PX1_W   = 11'(PLAT_X1);
  localparam logic [10:0] PY0_W   = 11'(PLAT_Y0);
  localparam logic [10:0] PY1_W   = 11'(PLAT_Y1);

  typedef enum logic [2:0] {IDLE, LOAD, STEP_X, STEP_Y, DONE} state_t;

  state_t state, state_nxt;

  logic frame_sync1, frame_sync2, frame_sync2_d;
  logic start;

  logic [9:0]  cx, cy;
  logic [5:0]  rem_x, rem_y;
  logic        x_neg, y_neg;
  logic        wall_w, head_w, ground_w;

  logic signed [6:0] dx, dy;
  logic [10:0] cand_x, cand_y;
  logic        x_blk, y_blk;
  logic        y_exit;

  // True when a sprite box with top-left (bx, by) is outside the play area
  // or overlaps the platform (inclusive rectangle on both axes).
  function automatic logic box_blocked(input logic [10:0] bx, input logic [10:0] by);
    logic [10:0] bx1, by1;
    logic        wall, floor_hit, plat;
    bx1       = bx + EDGE_W;
    by1       = by + EDGE_W;
    wall      = (bx1 > XMAX_W);
    floor_hit = (by1 >= FLOOR_W);
    plat      = (bx1 >= PX0_W) && (bx <= PX1_W) && (by1 >= PY0_W) && (by <= PY1_W);
    box_blocked = wall || floor_hit || plat;
  endfunction

  // Magnitude of a signed 7-bit step difference; |-63| still fits 6 bits.
  function automatic logic [5:0] step_mag(input logic signed [6:0] v);
    logic signed [6:0] a;
    a = v[6] ? -v : v;
    step_mag = a[5:0];
  endfunction

  // Two-flop synchronizer plus edge history for the asynchronous frame tick.
  always_ff @(posedge clk_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_sync1   <= 1'b0;
      frame_sync2   <= 1'b0;
      frame_sync2_d <= 1'b0;
    end else begin
      frame_sync1   <= frame_clk;
      frame_sync2   <= frame_sync1;
      frame_sync2_d <= frame_sync2;
    end
  end

  assign start = frame_sync2 & ~frame_sync2_d;

  // Requested net velocities and one-pixel candidates with their block tests.
  always_comb begin
    dx     = $signed({1'b0, Right_V}) - $signed({1'b0, Left_V});
    dy     = $signed({1'b0, Down_V}) - $signed({1'b0, Up_V});
    cand_x = x_neg ? ({1'b0, cx} - 11'd1) : ({1'b0, cx} + 11'd1);
    cand_y = y_neg ? ({1'b0, cy} - 11'd1) : ({1'b0, cy} + 11'd1);
    x_blk  = (x_neg && (cx == 10'd0)) || box_blocked(cand_x, {1'b0, cy});
    y_blk  = (y_neg && (cy == 10'd0)) || box_blocked({1'b0, cx}, cand_y);
    y_exit = (rem_y == 6'd0) || y_blk;
  end

  // State register.
  always_ff @(posedge clk_50 or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; Busy and Done decode directly from the state.
  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = LOAD;
      LOAD:   begin
        Busy      = 1'b1;
        state_nxt = STEP_X;
      end
      STEP_X: begin
        Busy = 1'b1;
        if ((rem_x == 6'd0) || x_blk) state_nxt = STEP_Y;
      end
      STEP_Y: begin
        Busy = 1'b1;
        if (y_exit) state_nxt = DONE;
      end
      DONE:   begin
        Busy      = 1'b1;
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working position walk. The outputs are registered on the final STEP_Y
  // cycle so that they change on the same cycle that Done is high.
  always_ff @(posedge clk_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      cx       <= '0;
      cy       <= '0;
      rem_x    <= '0;
      rem_y    <= '0;
      x_neg    <= 1'b0;
      y_neg    <= 1'b0;
      wall_w   <= 1'b0;
      head_w   <= 1'b0;
      ground_w <= 1'b0;
      X_Out    <= 10'(RESET_X);
      Y_Out    <= 10'(RESET_Y);
      Grounded <= 1'b0;
      Hit_Head <= 1'b0;
      Hit_Wall <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          cx       <= X_Pos;
          cy       <= Y_Pos;
          rem_x    <= step_mag(dx);
          rem_y    <= step_mag(dy);
          x_neg    <= dx[6];
          y_neg    <= dy[6];
          wall_w   <= 1'b0;
          head_w   <= 1'b0;
          ground_w <= 1'b0;
        end
        STEP_X: begin
          if (rem_x != 6'd0) begin
            if (x_blk) begin
              wall_w <= 1'b1;
            end else begin
              cx    <= cand_x[9:0];
              rem_x <= rem_x - 6'd1;
            end
          end
        end
        STEP_Y: begin
          if (rem_y != 6'd0) begin
            if (y_blk) begin
              if (y_neg) head_w   <= 1'b1;
              else       ground_w <= 1'b1;
            end else begin
              cy    <= cand_y[9:0];
              rem_y <= rem_y - 6'd1;
            end
          end
          if (y_exit) begin
            X_Out    <= cx;
            Y_Out    <= cy;
            Hit_Wall <= wall_w;
            Hit_Head <= head_w   | ((rem_y != 6'd0) && y_blk && y_neg);
            Grounded <= ground_w | ((rem_y != 6'd0) && y_blk && !y_neg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mario_motion_resolver.sv
// Bench for mario_motion_resolver: a pixel-walk reference model plus a
// per-cycle output compare, and literal expectations for each frame.

module tb_mario_motion_resolver;

  logic       clk_50 = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [9:0] X_Pos = '0, Y_Pos = '0;
  logic [5:0] Right_V = '0, Left_V = '0, Up_V = '0, Down_V = '0;
  logic [9:0] X_Out, Y_Out;
  logic       Done, Busy, Grounded, Hit_Head, Hit_Wall;

  int tests = 0;
  int fails = 0;

  int held_x = 0, held_y = 100, held_g = 0, held_h = 0, held_w = 0;
  int pend_x, pend_y, pend_g, pend_h, pend_w, pend_cyc;
  bit pending = 1'b0;
  int done_cnt = 0;
  int busy_run = 0;
  int last_cyc = 0;

  mario_motion_resolver dut (
    .clk_50   (clk_50),
    .Reset_n  (Reset_n),
    .frame_clk(frame_clk),
    .X_Pos    (X_Pos),
    .Y_Pos    (Y_Pos),
    .Right_V  (Right_V),
    .Left_V   (Left_V),
    .Up_V     (Up_V),
    .Down_V   (Down_V),
    .X_Out    (X_Out),
    .Y_Out    (Y_Out),
    .Done     (Done),
    .Busy     (Busy),
    .Grounded (Grounded),
    .Hit_Head (Hit_Head),
    .Hit_Wall (Hit_Wall)
  );

  always #10 clk_50 = ~clk_50;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // A sprite box at (x, y) is illegal if it leaves the screen, touches the
  // floor or overlaps the platform rectangle.
  function automatic bit model_blocked(input int x, input int y);
    return (x < 0) || (y < 0) || (x + 15 > 639) || (y + 15 >= 416) ||
           ((x + 15 >= 96) && (x <= 175) && (y + 15 >= 368) && (y <= 383));
  endfunction

  task automatic model_resolve(input int x, input int y, input int r, input int l,
                               input int u, input int d,
                               output int ox, output int oy, output int og,
                               output int oh, output int ow, output int ocyc);
    int kx, ky, sx, sy, mx, my;
    mx = 0; my = 0; og = 0; oh = 0; ow = 0;
    kx = r - l; sx = (kx < 0) ? -1 : 1; if (kx < 0) kx = -kx;
    ky = d - u; sy = (ky < 0) ? -1 : 1; if (ky < 0) ky = -ky;
    for (int i = 0; i < kx; i++) begin
      if (model_blocked(x + sx, y)) begin ow = 1; break; end
      x = x + sx; mx++;
    end
    for (int i = 0; i < ky; i++) begin
      if (model_blocked(x, y + sy)) begin
        if (sy > 0) og = 1; else oh = 1;
        break;
      end
      y = y + sy; my++;
    end
    ox = x; oy = y;
    ocyc = 1 + (mx + 1) + (my + 1) + 1;
  endtask

  // Per-cycle compare: outputs must hold their last value except on a Done
  // cycle, where they must show the model's result for the pending frame.
  initial begin
    forever begin
      @(negedge clk_50);
      if (!Reset_n) begin
        pending = 1'b0;
        held_x = 0; held_y = 100; held_g = 0; held_h = 0; held_w = 0;
        busy_run = 0;
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
      end else begin
        if (Busy) busy_run++;
        if (Done) begin
          done_cnt++;
          last_cyc = busy_run;
          check("done_expected", int'(pending), 1);
          if (pending) begin
            held_x = pend_x; held_y = pend_y;
            held_g = pend_g; held_h = pend_h; held_w = pend_w;
            pending = 1'b0;
          end
        end
        if (!Busy) busy_run = 0;
      end
      check("x_out", int'(X_Out), held_x);
      check("y_out", int'(Y_Out), held_y);
      check("grounded", int'(Grounded), held_g);
      check("hit_head", int'(Hit_Head), held_h);
      check("hit_wall", int'(Hit_Wall), held_w);
    end
  end

  task automatic set_frame(input int x, input int y, input int r, input int l,
                           input int u, input int d);
    @(posedge clk_50); #1;
    X_Pos = 10'(x); Y_Pos = 10'(y);
    Right_V = 6'(r); Left_V = 6'(l); Up_V = 6'(u); Down_V = 6'(d);
    model_resolve(x, y, r, l, u, d, pend_x, pend_y, pend_g, pend_h, pend_w, pend_cyc);
    pending = 1'b1;
  endtask

  task automatic pulse_frame();
    #3 frame_clk = 1'b1;
    repeat (4) @(posedge clk_50);
    #3 frame_clk = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk_50);
    #1;
    check({name, "_done_seen"}, done_cnt - d0, 1);
  endtask

  task automatic wait_busy(input string name);
    for (int i = 0; i < 20 && !Busy; i++) @(posedge clk_50);
    #1;
    check({name, "_busy_seen"}, int'(Busy), 1);
  endtask

  task automatic run_frame(input string name, input int x, input int y, input int r,
                           input int l, input int u, input int d,
                           input int lx, input int ly, input int lg, input int lh,
                           input int lw, input int lcyc);
    int d0;
    set_frame(x, y, r, l, u, d);
    d0 = done_cnt;
    pulse_frame();
    wait_done(name, d0);
    check({name, "_x"}, int'(X_Out), lx);
    check({name, "_y"}, int'(Y_Out), ly);
    check({name, "_grounded"}, int'(Grounded), lg);
    check({name, "_hit_head"}, int'(Hit_Head), lh);
    check({name, "_hit_wall"}, int'(Hit_Wall), lw);
    check({name, "_cycles"}, last_cyc, lcyc);
    check({name, "_model_cycles"}, last_cyc, pend_cyc);
    repeat (3) @(posedge clk_50);
    #1;
    check({name, "_idle"}, int'(Busy), 0);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk_50);
    #1;
    check("reset_x", int'(X_Out), 0);
    check("reset_y", int'(Y_Out), 100);
    check("reset_flags", int'({Grounded, Hit_Head, Hit_Wall}), 0);
    check("reset_busy", int'(Busy), 0);
    Reset_n = 1'b1;
    repeat (3) @(posedge clk_50);

    run_frame("fall",      0, 100,  0, 0, 0, 3,    0, 103, 0, 0, 0, 7);
    run_frame("floor",   200, 398,  0, 0, 0, 4,  200, 400, 1, 0, 0, 6);
    run_frame("left_0",    1, 100,  0, 2, 0, 0,    0, 100, 0, 0, 1, 5);
    run_frame("right_x", 622, 100,  3, 0, 0, 0,  624, 100, 0, 0, 1, 6);
    run_frame("head",    100, 386,  0, 0, 9, 0,  100, 384, 0, 1, 0, 6);
    run_frame("cancel",  300, 200,  5, 5, 7, 7,  300, 200, 0, 0, 0, 4);
    run_frame("plat_side", 60, 360, 30, 0, 0, 0,  80, 360, 0, 0, 1, 24);
    run_frame("max_vel", 300, 100, 63, 0, 0, 63, 363, 163, 0, 0, 0, 130);

    // Reset during STEP_X: outputs drop to reset values at once, no Done.
    set_frame(200, 100, 40, 0, 0, 0);
    d0 = done_cnt;
    pulse_frame();
    wait_busy("rst_mid");
    repeat (5) @(posedge clk_50);
    #1 Reset_n = 1'b0;
    #2;
    check("rst_mid_x", int'(X_Out), 0);
    check("rst_mid_y", int'(Y_Out), 100);
    check("rst_mid_busy", int'(Busy), 0);
    check("rst_mid_done", int'(Done), 0);
    repeat (3) @(posedge clk_50);
    #1 Reset_n = 1'b1;
    repeat (150) @(posedge clk_50);
    #1;
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_idle", int'(Busy), 0);

    // A second frame tick while busy is dropped: exactly one Done.
    set_frame(200, 100, 40, 0, 0, 0);
    d0 = done_cnt;
    pulse_frame();
    wait_busy("double");
    repeat (8) @(posedge clk_50);
    pulse_frame();
    wait_done("double", d0);
    check("double_x", int'(X_Out), 240);
    check("double_y", int'(Y_Out), 100);
    check("double_cycles", last_cyc, 44);
    repeat (150) @(posedge clk_50);
    #1;
    check("double_one_done", done_cnt - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mario_motion_resolver.md
# mario_motion_resolver

Per-frame motion resolver for the Mario sprite: the responder half of the movement interface. Once per frame it accepts the current 16x16 position and the requested Right/Left/Up/Down step velocities from the movement controller. It walks the sprite one pixel at a time against the screen bounds, the floor and one solid brick platform, and returns the resolved position plus contact flags. The controller latches the returned position as next frame's position.

## Interface
- MARIO_SIZE, 16: sprite edge length in pixels
- X_MAX, 639: rightmost legal pixel column
- FLOOR_Y, 416: first solid row of the floor
- PLAT_X0, 96 / PLAT_X1, 175: platform inclusive column range
- PLAT_Y0, 368 / PLAT_Y1, 383: platform inclusive row range
- RESET_X, 0 / RESET_Y, 100: X_Out/Y_Out value held during reset
- clk_50  in  1  sole clock; all logic is synchronous to it
- Reset_n  in  1  reset, asynchronous and active-low
- frame_clk  in  1  frame tick, asynchronous to clk_50
- X_Pos, Y_Pos  in  10 each  current top-left position, unsigned
- Right_V, Left_V, Up_V, Down_V  in  6 each  requested step magnitudes, unsigned
- X_Out, Y_Out  out  10 each  resolved top-left position
- Done  out  1  one-cycle pulse when X_Out/Y_Out update
- Busy  out  1  high from start detection until Done
- Grounded, Hit_Head, Hit_Wall  out  1 each  contact flags from the last resolve

## Operation
- frame_clk passes through a 2-flop synchronizer. Start = sync2 & ~sync2_d (rising edge).
- States: IDLE, LOAD, STEP_X, STEP_Y, DONE.
- IDLE: on Start, go to LOAD. In LOAD, sample X_Pos, Y_Pos and all velocities, and set Busy.
- LOAD: compute dx = Right_V - Left_V and dy = Down_V - Up_V as 7-bit signed. Store |dx| and |dy| in remaining counters and the signs as directions. Copy the position into working cx/cy. Clear the flags. Go to STEP_X.
- STEP_X, one cycle per attempt:
  - If the remaining count is 0, go to STEP_Y.
  - Otherwise compute candidate cx±1 and test it.
  - Test free: cx moves to the candidate and the count decrements.
  - Test blocked: cx is unchanged, Hit_Wall is set, and the state goes to STEP_Y.
- STEP_Y: same procedure on cy. A blocked downward attempt sets Grounded. A blocked upward attempt sets Hit_Head. Exit goes to DONE.
- Blocking test on candidate box [c, c+MARIO_SIZE-1] in each axis. The candidate is blocked if any of these hold:
  - moving left from cx=0, or moving up from cy=0 (never wraps below 0);
  - cx+MARIO_SIZE-1 > X_MAX;
  - cy+MARIO_SIZE-1 >= FLOOR_Y;
  - the box overlaps the platform rectangle (inclusive on both axes).
- Compute all comparisons at 11 bits, so there is no overflow at cx+15.
- DONE: X_Out<=cx, Y_Out<=cy, flags registered, Done=1 for this one cycle, Busy<=0, then IDLE.
- A Start that arrives while not in IDLE is dropped. No queueing.

## Timing
- Reset values: X_Out=RESET_X, Y_Out=RESET_Y, Done=0, Busy=0, Grounded=0, Hit_Head=0, Hit_Wall=0, state=IDLE, counters=0.
- frame_clk rise to Start: 2-3 clk_50 cycles (synchronizer).
- Cycle count from Start to Done inclusive is 1 (LOAD) + (mx+1) + (my+1) + 1 (DONE):
  - mx and my are the successful moves on each axis.
  - Maximum is 2+64+64 = 130 cycles, far below one frame period.
- Zero velocity: each STEP state takes exactly 1 cycle. Done still pulses and the outputs equal the inputs.
- X_Out/Y_Out/flags are stable between Done pulses. The controller may sample them at any time.
- Reset_n low mid-operation: all outputs immediately return to reset values, with no Done pulse. After release, the block waits for a fresh Start.
- Start on the same cycle as DONE: dropped.

## Test plan
- X=0,Y=100, Down_V=3, others 0 -> X_Out=0, Y_Out=103, Grounded=0, Done after 7 cycles from Start.
- X=200,Y=398, Down_V=4 -> Y_Out=400, Grounded=1 (candidate 401 hits FLOOR_Y).
- X=1,Y=100, Left_V=2 -> X_Out=0, Hit_Wall=1. Also X=622, Right_V=3 -> X_Out=624, Hit_Wall=1.
- X=100,Y=386, Up_V=9 -> Y_Out=384, Hit_Head=1 (platform bottom row 383).
- Right_V=Left_V=5 with Down_V=Up_V=7 -> position unchanged, all flags 0, Done pulses.
- Assert Reset_n low during STEP_X of a Right_V=40 resolve -> X_Out=0, Y_Out=100, Busy=0, no Done. A second frame_clk edge during Busy produces exactly one Done.
